// File: rtl/cnn_pkg.sv
// Shared types and frame geometry for the binarized MNIST classifier front end.
package cnn_pkg;

    localparam int IMG_W = 28;
    localparam int IMG_H = 28;
    localparam int IMG_PIX = IMG_W * IMG_H;
    localparam int PIX_W = 8;
    localparam int CNT_W = $clog2(IMG_PIX);
    localparam logic [PIX_W-1:0] THRESH = 8'd128;

    typedef logic [PIX_W-1:0] pix_t;
    typedef logic [CNT_W-1:0] cnt_t;
    typedef logic img_t [0:IMG_PIX-1];

    function automatic logic binarize(input pix_t p);
        return p >= THRESH;
    endfunction

endpackage

// File: rtl/image_stream_loader_if.sv
// Pixel-stream input and frame-output handshake of the image loader.
interface image_stream_loader_if;
    import cnn_pkg::*;

    logic pix_in_valid;
    logic pix_in_ready;
    pix_t pix_in_data;
    logic pix_in_last;
    logic image_out_valid;
    logic image_out_ready;
    img_t image_out;
    logic frame_err;

    // master is the surrounding system: it sources pixels and sinks frames
    modport master (
        output pix_in_valid, pix_in_data, pix_in_last, image_out_ready,
        input  pix_in_ready, image_out_valid, image_out, frame_err
    );

    modport slave (
        input  pix_in_valid, pix_in_data, pix_in_last, image_out_ready,
        output pix_in_ready, image_out_valid, image_out, frame_err
    );

endinterface

// File: rtl/image_stream_loader_bank.sv
// One frame buffer: a 784-bit register written one bit per cycle at a pixel index.
module image_stream_loader_bank
    import cnn_pkg::*;
(
    input  logic clk,
    input  logic we,
    input  cnt_t idx,
    input  logic bit_in,
    output img_t data_out
);

    img_t bank_q;
    img_t bank_d;

    always_comb begin
        bank_d = bank_q;
        if (we) begin
            bank_d[idx] = bit_in;
        end
    end

    // Contents are meaningless until the full flag says otherwise, so no reset.
    always_ff @(posedge clk) begin
        bank_q <= bank_d;
    end

    assign data_out = bank_q;

endmodule

// File: rtl/image_stream_loader.sv
// Binarizes a serial pixel stream into 28x28 frames using a two-bank ping-pong
// buffer and hands each complete frame downstream with a valid/ready handshake.
module image_stream_loader
    import cnn_pkg::*;
(
    input logic clk,
    input logic rst,
    image_stream_loader_if.slave bus
);

    cnt_t cnt_q, cnt_d;
    logic fill_q, fill_d;
    logic rd_q, rd_d;
    logic [1:0] full_q, full_d;
    logic err_q, err_d;

    logic accept;
    logic pop;
    logic at_end;
    img_t bank_data [2];

    assign bus.pix_in_ready = ~(full_q[0] & full_q[1]);
    assign accept = bus.pix_in_valid & bus.pix_in_ready;
    assign at_end = (cnt_q == cnt_t'(IMG_PIX - 1));
    assign bus.image_out_valid = full_q[rd_q];
    assign pop = bus.image_out_valid & bus.image_out_ready;
    assign bus.frame_err = err_q;

    for (genvar b = 0; b < 2; b++) begin : g_bank
        image_stream_loader_bank u_bank (
            .clk      (clk),
            .we       (accept && (fill_q == 1'(b))),
            .idx      (cnt_q),
            .bit_in   (binarize(bus.pix_in_data)),
            .data_out (bank_data[b])
        );
    end

    always_comb begin
        bus.image_out = bank_data[rd_q];
    end

    // Commit and pop always touch different banks, so both may act in one cycle.
    always_comb begin
        cnt_d = cnt_q;
        fill_d = fill_q;
        rd_d = rd_q;
        full_d = full_q;
        err_d = 1'b0;
        if (accept) begin
            if (at_end) begin
                full_d[fill_q] = 1'b1;
                fill_d = ~fill_q;
                cnt_d = '0;
                err_d = ~bus.pix_in_last;
            end else if (bus.pix_in_last) begin
                cnt_d = '0;
                err_d = 1'b1;
            end else begin
                cnt_d = cnt_q + cnt_t'(1);
            end
        end
        if (pop) begin
            full_d[rd_q] = 1'b0;
            rd_d = ~rd_q;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
            fill_q <= 1'b0;
            rd_q <= 1'b0;
            full_q <= 2'b00;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            fill_q <= fill_d;
            rd_q <= rd_d;
            full_q <= full_d;
            err_q <= err_d;
        end
    end

endmodule

// File: tb/tb_image_stream_loader.sv
// Directed self-checking bench for image_stream_loader.
module tb_image_stream_loader;
    import cnn_pkg::*;

    logic clk;
    logic rst;
    int vectors;
    int miscompares;
    int err_count;

    image_stream_loader_if bus ();

    image_stream_loader dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (bus.frame_err === 1'b1) err_count++;
    end

    initial begin
        #3_000_000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [IMG_PIX-1:0] got,
                               input logic [IMG_PIX-1:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic pix_t pixVal(input int mode, input int i);
        case (mode)
            0: return pix_t'(i % 256);
            1: return 8'd255;
            2: return 8'd0;
            default: return pix_t'((i * 37 + 11) % 256);
        endcase
    endfunction

    function automatic logic [IMG_PIX-1:0] expFrame(input int mode);
        logic [IMG_PIX-1:0] e;
        for (int i = 0; i < IMG_PIX; i++) e[i] = (pixVal(mode, i) >= 8'd128);
        return e;
    endfunction

    function automatic logic [IMG_PIX-1:0] packImg(input img_t v);
        logic [IMG_PIX-1:0] p;
        for (int i = 0; i < IMG_PIX; i++) p[i] = v[i];
        return p;
    endfunction

    function automatic int popCount(input logic [IMG_PIX-1:0] v);
        int n = 0;
        for (int i = 0; i < IMG_PIX; i++) n += int'(v[i]);
        return n;
    endfunction

    // Called on a negedge; returns on the negedge after the pixel was accepted.
    task automatic applyStimulus(input pix_t d, input logic l);
        int guard = 0;
        bus.pix_in_valid = 1'b1;
        bus.pix_in_data = d;
        bus.pix_in_last = l;
        while (bus.pix_in_ready !== 1'b1 && guard < 5000) begin
            @(negedge clk);
            guard++;
        end
        if (guard >= 5000) checkOutput("ready_timeout", 0, 1);
        @(negedge clk);
        bus.pix_in_valid = 1'b0;
        bus.pix_in_last = 1'b0;
    endtask

    task automatic sendFrame(input int mode, input int n, input int last_at);
        for (int i = 0; i < n; i++) applyStimulus(pixVal(mode, i), i == last_at);
    endtask

    task automatic popFrame();
        bus.image_out_ready = 1'b1;
        @(negedge clk);
        bus.image_out_ready = 1'b0;
    endtask

    initial begin
        int e0;
        vectors = 0;
        miscompares = 0;
        err_count = 0;
        rst = 1'b1;
        bus.pix_in_valid = 1'b0;
        bus.pix_in_data = '0;
        bus.pix_in_last = 1'b0;
        bus.image_out_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        checkOutput("reset_ready", bus.pix_in_ready, 1);
        checkOutput("reset_valid", bus.image_out_valid, 0);
        checkOutput("reset_err", bus.frame_err, 0);

        // single frame, latency and content
        sendFrame(0, IMG_PIX - 1, -1);
        checkOutput("t1_valid_before_last", bus.image_out_valid, 0);
        applyStimulus(pixVal(0, IMG_PIX - 1), 1'b1);
        checkOutput("t1_valid", bus.image_out_valid, 1);
        checkOutput("t1_image", packImg(bus.image_out), expFrame(0));
        checkOutput("t1_popcount", popCount(packImg(bus.image_out)), 384);
        checkOutput("t1_no_err", err_count, 0);
        popFrame();
        checkOutput("t1_valid_after_pop", bus.image_out_valid, 0);

        // backpressure with three frames
        sendFrame(0, IMG_PIX, IMG_PIX - 1);
        sendFrame(3, IMG_PIX, IMG_PIX - 1);
        checkOutput("t2_ready_low", bus.pix_in_ready, 0);
        checkOutput("t2_frame1", packImg(bus.image_out), expFrame(0));
        fork
            sendFrame(1, IMG_PIX, IMG_PIX - 1);
            begin
                repeat (5) @(negedge clk);
                checkOutput("t2_frame1_held", packImg(bus.image_out), expFrame(0));
                checkOutput("t2_valid_held", bus.image_out_valid, 1);
                checkOutput("t2_ready_held", bus.pix_in_ready, 0);
                popFrame();
                checkOutput("t2_frame2_valid", bus.image_out_valid, 1);
                checkOutput("t2_frame2", packImg(bus.image_out), expFrame(3));
                checkOutput("t2_ready_back", bus.pix_in_ready, 1);
            end
        join
        checkOutput("t2_full_again", bus.pix_in_ready, 0);
        popFrame();
        checkOutput("t2_frame3", packImg(bus.image_out), expFrame(1));
        popFrame();
        checkOutput("t2_drained", bus.image_out_valid, 0);
        checkOutput("t2_no_err", err_count, 0);

        // early last
        e0 = err_count;
        sendFrame(0, 101, 100);
        checkOutput("t3_err_pulse", bus.frame_err, 1);
        checkOutput("t3_no_valid", bus.image_out_valid, 0);
        @(negedge clk);
        checkOutput("t3_err_one_cycle", bus.frame_err, 0);
        checkOutput("t3_err_count", err_count - e0, 1);
        sendFrame(1, IMG_PIX, IMG_PIX - 1);
        checkOutput("t3_all_ones", packImg(bus.image_out), {IMG_PIX{1'b1}});
        popFrame();

        // missing last
        e0 = err_count;
        sendFrame(3, IMG_PIX, -1);
        checkOutput("t4_err_pulse", bus.frame_err, 1);
        checkOutput("t4_valid", bus.image_out_valid, 1);
        checkOutput("t4_image", packImg(bus.image_out), expFrame(3));
        popFrame();
        sendFrame(0, IMG_PIX, IMG_PIX - 1);
        checkOutput("t4_next_frame", packImg(bus.image_out), expFrame(0));
        checkOutput("t4_err_count", err_count - e0, 1);
        popFrame();

        // commit and pop in the same cycle
        sendFrame(1, IMG_PIX, IMG_PIX - 1);
        sendFrame(2, IMG_PIX - 1, -1);
        checkOutput("t5_ready", bus.pix_in_ready, 1);
        bus.pix_in_valid = 1'b1;
        bus.pix_in_data = pixVal(2, IMG_PIX - 1);
        bus.pix_in_last = 1'b1;
        bus.image_out_ready = 1'b1;
        @(negedge clk);
        bus.pix_in_valid = 1'b0;
        bus.pix_in_last = 1'b0;
        bus.image_out_ready = 1'b0;
        checkOutput("t5_valid", bus.image_out_valid, 1);
        checkOutput("t5_frame2", packImg(bus.image_out), {IMG_PIX{1'b0}});
        popFrame();
        checkOutput("t5_drained", bus.image_out_valid, 0);

        // reset mid-frame with a held frame
        sendFrame(0, IMG_PIX, IMG_PIX - 1);
        sendFrame(1, 400, -1);
        checkOutput("t6_held", bus.image_out_valid, 1);
        rst = 1'b1;
        #1;
        checkOutput("t6_async_drop", bus.image_out_valid, 0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checkOutput("t6_ready", bus.pix_in_ready, 1);
        checkOutput("t6_valid", bus.image_out_valid, 0);
        sendFrame(2, IMG_PIX, IMG_PIX - 1);
        checkOutput("t6_valid_new", bus.image_out_valid, 1);
        checkOutput("t6_all_zero", packImg(bus.image_out), {IMG_PIX{1'b0}});
        popFrame();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
